sysp_icb_bridge: RTL and testbench

Parametrised ICB-slave-to-peripheral-register bridge for the system-peripheral region. It decodes a slot field of the command address into SLOT_NUM peripheral select strobes and drives a shared register bus. Unlike a fixed 16-slot decoder, it supports:
- per-slot wait states through a p_ready handshake;
- responses for both writes and reads;
- an error response on unmapped slots or on timeout.

It sits between the core's ICB sysp master and the uart/spi/timer/fpioa register blocks.

---
 rtl/sysp_icb_bridge.sv | 194 +++++++++++++++++++
 tb/tb_sysp_icb_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysp_icb_bridge.sv
// sysp_icb_bridge: ICB slave to system-peripheral register bus bridge.
// Decodes a 4-bit slot field of the command address into one-hot
// per-slot strobes and waits on a per-slot p_ready handshake.
// A response is returned for every command. Unmapped slots and
// timeouts produce an error response.
// The optional macro SYSP_BRIDGE_ERR_LOG_EN adds the err_addr/err_cnt
// error log outputs.
module sysp_icb_bridge #(
  parameter int unsigned SLOT_NUM     = 16,
  parameter int unsigned SLOT_SEL_LSB = 8,
  parameter int unsigned REG_AW       = 8,
  parameter int unsigned DW           = 32,
  parameter logic [15:0] SLOT_MASK    = 16'hFFFF,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   icb_cmd_valid,
  output logic                   icb_cmd_ready,
  input  logic [31:0]            icb_cmd_addr,
  input  logic                   icb_cmd_read,
  input  logic [DW-1:0]          icb_cmd_wdata,
  input  logic [DW/8-1:0]        icb_cmd_wmask,
  output logic                   icb_rsp_valid,
  input  logic                   icb_rsp_ready,
  output logic                   icb_rsp_err,
  output logic [DW-1:0]          icb_rsp_rdata,
  output logic [REG_AW-1:0]      p_addr,
  output logic [DW-1:0]          p_wdata,
  output logic [DW/8-1:0]        p_sel,
  output logic [SLOT_NUM-1:0]    p_we,
  output logic [SLOT_NUM-1:0]    p_rd,
  input  logic [SLOT_NUM*DW-1:0] p_rdata,
  input  logic [SLOT_NUM-1:0]    p_ready,
  output logic                   err_irq
`ifdef SYSP_BRIDGE_ERR_LOG_EN
  ,
  output logic [31:0]            err_addr,
  output logic [7:0]             err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RSP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wmask_q;
  logic              read_q;
  logic [3:0]        slot_q;
  logic              first_q;
  logic [7:0]        cnt_q;
  logic              rsp_err_q;
  logic [DW-1:0]     rsp_rdata_q;
  logic              err_irq_q;

  logic [3:0]        cmd_slot;
  logic              cmd_mapped;
  logic              cmd_hs;
  logic              sel_ready;
  logic [DW-1:0]     sel_rdata;
  logic              timeout_hit;
  logic              enter_rsp;
  logic              enter_err;
  logic [DW-1:0]     rdata_d;

  assign cmd_slot    = icb_cmd_addr[SLOT_SEL_LSB +: 4];
  assign cmd_mapped  = (32'(cmd_slot) < SLOT_NUM) && SLOT_MASK[cmd_slot];
  assign cmd_hs      = icb_cmd_valid && (state_q == IDLE);
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // Select ready and read data of the latched slot
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < SLOT_NUM; i++) begin
      if (slot_q == 4'(i)) begin
        sel_ready = p_ready[i];
        sel_rdata = p_rdata[i*DW +: DW];
      end
    end
  end

  // Next-state and response-capture decisions
  always_comb begin
    state_d   = state_q;
    enter_rsp = 1'b0;
    enter_err = 1'b0;
    rdata_d   = '0;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          if (cmd_mapped) begin
            state_d = ACCESS;
          end else begin
            state_d   = RSP;
            enter_rsp = 1'b1;
            enter_err = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d   = RSP;
          enter_rsp = 1'b1;
          rdata_d   = read_q ? sel_rdata : '0;
        end else if (timeout_hit) begin
          state_d   = RSP;
          enter_rsp = 1'b1;
          enter_err = 1'b1;
        end
      end
      RSP: begin
        if (icb_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Command latch, wait counter, response and irq registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      read_q      <= 1'b0;
      slot_q      <= '0;
      first_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_irq_q   <= 1'b0;
    end else begin
      first_q   <= cmd_hs && cmd_mapped;
      err_irq_q <= enter_err;
      if (cmd_hs) begin
        addr_q  <= icb_cmd_addr;
        wdata_q <= icb_cmd_wdata;
        wmask_q <= icb_cmd_wmask;
        read_q  <= icb_cmd_read;
        slot_q  <= cmd_slot;
        cnt_q   <= '0;
      end else if ((state_q == ACCESS) && !sel_ready) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (enter_rsp) begin
        rsp_err_q   <= enter_err;
        rsp_rdata_q <= rdata_d;
      end else if ((state_q == RSP) && icb_rsp_ready) begin
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= '0;
      end
    end
  end

`ifdef SYSP_BRIDGE_ERR_LOG_EN
  // Error log: address of the last error response and a saturating count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (enter_err) begin
      err_addr <= (state_q == IDLE) ? icb_cmd_addr : addr_q;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

  // One-hot strobes, only in the first ACCESS cycle
  always_comb begin
    p_we = '0;
    p_rd = '0;
    for (int unsigned i = 0; i < SLOT_NUM; i++) begin
      p_we[i] = first_q && !read_q && (slot_q == 4'(i));
      p_rd[i] = first_q &&  read_q && (slot_q == 4'(i));
    end
  end

  assign icb_cmd_ready = (state_q == IDLE);
  assign icb_rsp_valid = (state_q == RSP);
  assign icb_rsp_err   = rsp_err_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign p_addr        = {addr_q[REG_AW-1:2], 2'b00};
  assign p_wdata       = wdata_q;
  assign p_sel         = wmask_q;
  assign err_irq       = err_irq_q;

endmodule

// File: tb/tb_sysp_icb_bridge.sv
// Testbench for sysp_icb_bridge: randomized ICB commands against a
// transaction-level model; a monitor checks strobes and responses from
// scoreboard queues filled when commands are issued.
module tb_sysp_icb_bridge;

  localparam int unsigned SN   = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned TO   = 4;
  localparam logic [15:0] MASK = 16'h800F;

  logic            clk;
  logic            rst_n;
  logic            icb_cmd_valid;
  logic            icb_cmd_ready;
  logic [31:0]     icb_cmd_addr;
  logic            icb_cmd_read;
  logic [DW-1:0]   icb_cmd_wdata;
  logic [3:0]      icb_cmd_wmask;
  logic            icb_rsp_valid;
  logic            icb_rsp_ready;
  logic            icb_rsp_err;
  logic [DW-1:0]   icb_rsp_rdata;
  logic [7:0]      p_addr;
  logic [DW-1:0]   p_wdata;
  logic [3:0]      p_sel;
  logic [SN-1:0]   p_we;
  logic [SN-1:0]   p_rd;
  logic [SN*DW-1:0] p_rdata;
  logic [SN-1:0]   p_ready;
  logic            err_irq;
`ifdef SYSP_BRIDGE_ERR_LOG_EN
  logic [31:0]     err_addr;
  logic [7:0]      err_cnt;
`endif

  sysp_icb_bridge #(
    .SLOT_NUM(SN), .SLOT_SEL_LSB(8), .REG_AW(8), .DW(DW),
    .SLOT_MASK(MASK), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_sel(p_sel),
    .p_we(p_we), .p_rd(p_rd), .p_rdata(p_rdata), .p_ready(p_ready),
    .err_irq(err_irq)
`ifdef SYSP_BRIDGE_ERR_LOG_EN
    , .err_addr(err_addr), .err_cnt(err_cnt)
`endif
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  ecnt;
    logic [31:0] eaddr;
  } rsp_t;

  typedef struct packed {
    logic [15:0] we;
    logic [15:0] rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } stb_t;

  rsp_t rsp_q[$];
  stb_t stb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_ecnt = 0;
  logic [31:0] model_eaddr = '0;
  bit   rr_auto = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Random response back-pressure when the driver is not steering it
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_auto) icb_rsp_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Monitor: strobe and response scoreboard
  initial begin
    bit   prev_hold;
    stb_t s;
    rsp_t e;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (|p_we || |p_rd) begin
          if (stb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL strobe: unexpected we=%h rd=%h", p_we, p_rd);
          end else begin
            s = stb_q.pop_front();
            chk("p_we", p_we, s.we);
            chk("p_rd", p_rd, s.rd);
            chk("p_addr", p_addr, s.addr);
            chk("p_wdata", p_wdata, s.wdata);
            chk("p_sel", p_sel, s.sel);
          end
        end
        if (icb_rsp_valid) begin
          chk("cmd_ready_in_rsp", icb_cmd_ready, 0);
          if (rsp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL rsp: unexpected response err=%b rdata=%h", icb_rsp_err, icb_rsp_rdata);
          end else begin
            e = rsp_q[0];
            chk("rsp_err", icb_rsp_err, e.err);
            chk("rsp_rdata", icb_rsp_rdata, e.rdata);
            chk("err_irq", err_irq, (!prev_hold && e.err));
`ifdef SYSP_BRIDGE_ERR_LOG_EN
            chk("err_cnt", err_cnt, e.ecnt);
            chk("err_addr", err_addr, e.eaddr);
`endif
            if (icb_rsp_ready) void'(rsp_q.pop_front());
          end
        end else if (err_irq) begin
          chk("err_irq_stray", err_irq, 0);
        end
        prev_hold = icb_rsp_valid && !icb_rsp_ready;
      end
    end
  end

  task automatic rand_bus(input logic [3:0] slot, input logic [31:0] d, input bit rdy);
    logic [SN-1:0]    pr;
    logic [SN*DW-1:0] prd;
    pr = SN'($urandom());
    pr[slot] = rdy;
    for (int i = 0; i < int'(SN); i++) prd[i*DW +: DW] = $urandom();
    prd[int'(slot)*DW +: DW] = d;
    p_ready = pr;
    p_rdata = prd;
  endtask

  task automatic wait_cmd_ready(input string name);
    int n;
    n = 0;
    while (!icb_cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!icb_cmd_ready) bound_fail(name);
  endtask

  // One complete transaction; w = p_ready low cycles before ready
  task automatic do_txn(input logic [31:0] addr, input logic rd, input logic [31:0] wdata,
                        input logic [3:0] wmask, input logic [31:0] d,
                        input int unsigned w, input bit hold);
    logic [3:0]  slot;
    bit          mapped;
    int unsigned lat_exp;
    int unsigned n;
    rsp_t e;
    stb_t s;
    slot   = addr[11:8];
    mapped = MASK[slot];
    wait_cmd_ready("cmd_ready_wait");
    if (hold) begin
      rr_auto = 1'b0;
      icb_rsp_ready = 1'b0;
    end
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = addr;
    icb_cmd_read  = rd;
    icb_cmd_wdata = wdata;
    icb_cmd_wmask = wmask;
    e.err = !mapped || (w >= TO);
    e.rdata = (e.err || !rd) ? 32'h0 : d;
    if (e.err) begin
      if (model_ecnt < 255) model_ecnt++;
      model_eaddr = addr;
    end
    e.ecnt  = 8'(model_ecnt);
    e.eaddr = model_eaddr;
    rsp_q.push_back(e);
    if (mapped) begin
      s.we    = rd ? 16'h0 : (16'h1 << slot);
      s.rd    = rd ? (16'h1 << slot) : 16'h0;
      s.addr  = {addr[7:2], 2'b00};
      s.wdata = wdata;
      s.sel   = wmask;
      stb_q.push_back(s);
    end
    lat_exp = !mapped ? 1 : ((w < TO) ? w + 2 : TO + 1);
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
    n = 1;
    while (!icb_rsp_valid && n <= 20) begin
      chk("p_addr_hold", p_addr, {addr[7:2], 2'b00});
      chk("p_wdata_hold", p_wdata, wdata);
      rand_bus(slot, d, (n > w));
      @(posedge clk); #1; n++;
    end
    chk("latency", n, lat_exp);
    rand_bus(slot, $urandom(), $urandom_range(0, 1) == 1);
    if (hold) begin
      for (int k = 0; k < 10; k++) begin
        chk("hold_rsp_valid", icb_rsp_valid, 1);
        chk("hold_cmd_ready", icb_cmd_ready, 0);
        @(posedge clk); #1;
      end
      icb_rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_cmd_ready", icb_cmd_ready, 1);
      chk("release_rsp_valid", icb_rsp_valid, 0);
      icb_rsp_ready = 1'b0;
      rr_auto = 1'b1;
    end
    wait_cmd_ready("rsp_drain_wait");
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  sl;
    logic [3:0]  mapped_slots [5];
    mapped_slots = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd15};
    rst_n = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_read  = 1'b0;
    icb_cmd_wdata = '0;
    icb_cmd_wmask = '0;
    icb_rsp_ready = 1'b0;
    p_ready = '0;
    p_rdata = '0;
    #22;
    chk("rst_cmd_ready", icb_cmd_ready, 1);
    chk("rst_rsp_valid", icb_rsp_valid, 0);
    chk("rst_rsp_err", icb_rsp_err, 0);
    chk("rst_rsp_rdata", icb_rsp_rdata, 0);
    chk("rst_p_we", p_we, 0);
    chk("rst_p_rd", p_rd, 0);
    chk("rst_err_irq", err_irq, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn(32'h0000_0304, 1'b1, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1'b0);
    do_txn(32'h0000_0008, 1'b0, 32'h1234_5678, 4'h3, 32'hCAFE_0000, 3, 1'b0);
    do_txn(32'h0000_0500, 1'b1, 32'h0, 4'h0, 32'h5555_AAAA, 0, 1'b0);
    do_txn(32'h0000_0200, 1'b1, 32'h0, 4'h0, 32'h7777_1111, 30, 1'b0);
    do_txn(32'h0000_0F10, 1'b0, 32'hA5A5_5A5A, 4'hF, 32'h0, 1, 1'b1);
    do_txn(32'h0000_0F14, 1'b1, 32'h0, 4'h0, 32'h0BAD_F00D, 2, 1'b1);

    for (int t = 0; t < 60; t++) begin
      a = $urandom();
      if ($urandom_range(0, 9) < 7) sl = mapped_slots[$urandom_range(0, 4)];
      else sl = 4'($urandom_range(0, 15));
      a[11:8] = sl;
      do_txn(a, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom()), $urandom(),
             $urandom_range(0, 5), 1'b0);
    end

    // Reset while the strobe of a pending read is active
    wait_cmd_ready("pre_reset_wait");
    p_ready = '0;
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = 32'h0000_0208;
    icb_cmd_read  = 1'b1;
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", icb_rsp_valid, 0);
    chk("mid_rst_cmd_ready", icb_cmd_ready, 1);
    chk("mid_rst_p_we", p_we, 0);
    chk("mid_rst_p_rd", p_rd, 0);
    stb_q.delete();
    rsp_q.delete();
    model_ecnt  = 0;
    model_eaddr = '0;
    #10;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("post_rst_rsp_valid", icb_rsp_valid, 0);
      chk("post_rst_cmd_ready", icb_cmd_ready, 1);
    end
    do_txn(32'h0000_0104, 1'b1, 32'h0, 4'h0, 32'h0102_0304, 0, 1'b0);
    do_txn(32'h0000_0900, 1'b0, 32'h0, 4'h1, 32'h0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("stb_q_drained", stb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
